// File: rtl/spike_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : spike_event_scheduler
// Description : Timestep scheduler for a time-multiplexed neuron datapath.
//               Holds spike events in a single FIFO whose write port is
//               shared between external spikes and recurrent fire events.
//               Each timestep snapshots the queue, sweeps all neurons once
//               per queued event (accumulate), then sweeps all neurons once
//               more (update) and collects fire events for the next step.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_event_scheduler #(
   parameter int NR_DEPTH         = 16,
   parameter int SR_DEPTH         = 16384,
   parameter int EVQ_DEPTH        = 8,
   parameter int MAX_NETWORK_TIME = 65536
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic                                ext_valid,
   input  logic [$clog2(SR_DEPTH)-1:0]         ext_index,
   output logic                                ext_ready,
   input  logic                                fire,
   output logic [$clog2(NR_DEPTH)-1:0]         c_neuron_index,
   output logic [$clog2(SR_DEPTH)-1:0]         c_synapse_index,
   output logic                                c_neuron_we,
   output logic                                c_mode,
   output logic [$clog2(MAX_NETWORK_TIME)-1:0] timestep,
   output logic                                busy,
   output logic                                done,
   output logic [7:0]                          drop_count
);

   // ------------------------------------------------------------------------
   // Derived widths and constants
   // ------------------------------------------------------------------------
   localparam int c_NW = $clog2(NR_DEPTH);
   localparam int c_SW = $clog2(SR_DEPTH);
   localparam int c_TW = $clog2(MAX_NETWORK_TIME);
   localparam int c_PW = $clog2(EVQ_DEPTH);
   localparam int c_CW = $clog2(EVQ_DEPTH + 1);

   localparam logic [c_NW-1:0] c_LAST_NEURON = c_NW'(NR_DEPTH - 1);
   localparam logic [c_TW-1:0] c_LAST_TS     = c_TW'(MAX_NETWORK_TIME - 1);
   localparam logic [c_CW-1:0] c_FULL_COUNT  = c_CW'(EVQ_DEPTH);
   localparam logic [c_CW-1:0] c_ONE_EVENT   = c_CW'(1);
   localparam logic [7:0]      c_DROP_MAX    = 8'hFF;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_TS_START = 2'd1,
      S_ACC      = 2'd2,
      S_UPDATE   = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t            r_state;
   logic [c_NW-1:0]   r_nidx;
   logic [c_TW-1:0]   r_ts;
   logic [c_CW-1:0]   r_pending;
   logic [c_SW-1:0]   r_mem [EVQ_DEPTH];
   logic [c_PW-1:0]   r_wr_ptr;
   logic [c_PW-1:0]   r_rd_ptr;
   logic [c_CW-1:0]   r_count;
   logic [7:0]        r_drop;

   // ------------------------------------------------------------------------
   // Combinational nets
   // ------------------------------------------------------------------------
   state_t            w_next_state;
   logic              w_last_neuron;
   logic              w_full;
   logic              w_fire_req;
   logic              w_fire_push;
   logic              w_drop;
   logic              w_ext_push;
   logic              w_push;
   logic [c_SW-1:0]   w_push_row;
   logic              w_pop_req;
   logic              w_pop;
   logic              w_sweep;
   logic              w_ts_wrap;

   assign w_last_neuron = (r_nidx == c_LAST_NEURON);
   assign w_full        = (r_count == c_FULL_COUNT);
   assign w_sweep       = (r_state == S_ACC) || (r_state == S_UPDATE);
   assign w_ts_wrap     = (r_ts == c_LAST_TS);

   // Recurrent fire events own the write port during the update sweep; a
   // fire that finds the queue full is counted as a drop instead.
   assign w_fire_req  = (r_state == S_UPDATE) && fire;
   assign w_fire_push = w_fire_req && !w_full;
   assign w_drop      = w_fire_req && w_full;

   // External readiness deliberately ignores a same-cycle pop so that it
   // never depends on the sweep position.
   assign ext_ready  = !reset && !w_full && !w_fire_req;
   assign w_ext_push = ext_valid && ext_ready;

   assign w_push     = w_fire_push || w_ext_push;
   assign w_push_row = w_fire_push ? c_SW'(r_nidx) : ext_index;

   // The pending snapshot never exceeds the stored count, the guard only
   // protects the pointers against an inconsistent state.
   assign w_pop = w_pop_req && (r_count != '0);

   assign c_neuron_index = r_nidx;
   assign timestep       = r_ts;
   assign busy           = (r_state != S_IDLE);
   assign drop_count     = r_drop;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode and datapath control outputs
   always_comb begin
      w_next_state    = r_state;
      c_neuron_we     = 1'b0;
      c_mode          = 1'b0;
      c_synapse_index = '0;
      w_pop_req       = 1'b0;
      done            = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state = S_TS_START;
            end
         end
         S_TS_START: begin
            // Decide on the live count, which is what the snapshot latches.
            w_next_state = (r_count != '0) ? S_ACC : S_UPDATE;
         end
         S_ACC: begin
            c_neuron_we     = 1'b1;
            c_synapse_index = r_mem[r_rd_ptr];
            if (w_last_neuron) begin
               w_pop_req = 1'b1;
               if (r_pending == c_ONE_EVENT) begin
                  w_next_state = S_UPDATE;
               end
            end
         end
         S_UPDATE: begin
            c_neuron_we = 1'b1;
            c_mode      = 1'b1;
            if (w_last_neuron) begin
               if (w_ts_wrap) begin
                  done         = 1'b1;
                  w_next_state = S_IDLE;
               end else begin
                  w_next_state = S_TS_START;
               end
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Neuron sweep counter, parked at zero outside the sweep states
   always_ff @(posedge clk) begin
      if (reset) begin
         r_nidx <= '0;
      end else if (w_sweep && !w_last_neuron) begin
         r_nidx <= r_nidx + 1'b1;
      end else begin
         r_nidx <= '0;
      end
   end

   // Snapshot of events to apply in this timestep
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= '0;
      end else if (r_state == S_TS_START) begin
         r_pending <= r_count;
      end else if ((r_state == S_ACC) && w_last_neuron) begin
         r_pending <= r_pending - 1'b1;
      end
   end

   // Timestep index; holds its final value after the run completes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ts <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_ts <= '0;
      end else if ((r_state == S_UPDATE) && w_last_neuron && !w_ts_wrap) begin
         r_ts <= r_ts + 1'b1;
      end
   end

   // Event storage; contents are only meaningful below the count
   always_ff @(posedge clk) begin
      if (w_push && !reset) begin
         r_mem[r_wr_ptr] <= w_push_row;
      end
   end

   // Queue pointers and occupancy; pointers wrap on the power-of-two depth
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Saturating count of fire events lost to a full queue
   always_ff @(posedge clk) begin
      if (reset) begin
         r_drop <= '0;
      end else if (w_drop && (r_drop != c_DROP_MAX)) begin
         r_drop <= r_drop + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spike_event_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spike_event_scheduler
// Description : Directed bench for spike_event_scheduler with a queue-based
//               reference model compared every cycle, plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_event_scheduler;

   localparam int NR   = 16;
   localparam int QD   = 8;
   localparam int MAXT = 65536;
   localparam int K_TS  = 0;
   localparam int K_ACC = 1;
   localparam int K_UPD = 2;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        start     = 1'b0;
   logic        start4    = 1'b0;
   logic        ext_valid = 1'b0;
   logic        fire      = 1'b0;
   logic [13:0] ext_index = '0;

   logic        ext_ready, c_neuron_we, c_mode, busy, done;
   logic [3:0]  c_neuron_index;
   logic [13:0] c_synapse_index;
   logic [15:0] timestep;
   logic [7:0]  drop_count;

   logic        ext_ready4, c_neuron_we4, c_mode4, busy4, done4;
   logic [3:0]  c_neuron_index4;
   logic [13:0] c_synapse_index4;
   logic [1:0]  timestep4;
   logic [7:0]  drop_count4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   spike_event_scheduler dut (
      .clk(clk), .reset(reset), .start(start),
      .ext_valid(ext_valid), .ext_index(ext_index), .ext_ready(ext_ready),
      .fire(fire), .c_neuron_index(c_neuron_index),
      .c_synapse_index(c_synapse_index), .c_neuron_we(c_neuron_we),
      .c_mode(c_mode), .timestep(timestep), .busy(busy), .done(done),
      .drop_count(drop_count)
   );

   spike_event_scheduler #(.MAX_NETWORK_TIME(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4),
      .ext_valid(1'b0), .ext_index(14'd0), .ext_ready(ext_ready4),
      .fire(1'b0), .c_neuron_index(c_neuron_index4),
      .c_synapse_index(c_synapse_index4), .c_neuron_we(c_neuron_we4),
      .c_mode(c_mode4), .timestep(timestep4), .busy(busy4), .done(done4),
      .drop_count(drop_count4)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: the queue, plus a plan of the outputs each remaining
   // cycle of the current timestep must show.
   // ------------------------------------------------------------------------
   typedef struct {
      int kind;
      int n;
      int syn;
   } ent_t;

   ent_t plan[$];
   int   q[$];
   int   m_ts    = 0;
   int   m_drops = 0;
   bit   m_run   = 1'b0;
   bit   chk_en  = 1'b0;

   function automatic ent_t mk(input int kind, input int n, input int syn);
      ent_t e;
      e.kind = kind;
      e.n    = n;
      e.syn  = syn;
      return e;
   endfunction

   always @(posedge clk) begin
      ent_t cur;
      int   snap[$];
      bit   was_run, fire_req, full, ext_acc;
      if (reset) begin
         q.delete();
         plan.delete();
         m_run   = 1'b0;
         m_ts    = 0;
         m_drops = 0;
         chk_en  = 1'b1;
      end else begin
         was_run = m_run;
         cur = was_run ? plan[0] : mk(-1, 0, 0);
         snap = q;
         fire_req = was_run && (cur.kind == K_UPD) && fire;
         full = (q.size() == QD);
         ext_acc = ext_valid && !full && !fire_req;
         if (fire_req) begin
            if (full) begin
               if (m_drops < 255) m_drops++;
            end else begin
               q.push_back(cur.n);
            end
         end
         if (ext_acc) q.push_back(int'(ext_index));
         if (was_run && cur.kind == K_ACC && cur.n == NR - 1) void'(q.pop_front());
         if (was_run) begin
            void'(plan.pop_front());
            if (cur.kind == K_TS) begin
               foreach (snap[i])
                  for (int n = 0; n < NR; n++) plan.push_back(mk(K_ACC, n, snap[i]));
               for (int n = 0; n < NR; n++) plan.push_back(mk(K_UPD, n, 0));
            end else if (cur.kind == K_UPD && cur.n == NR - 1) begin
               if (m_ts == MAXT - 1) begin
                  m_run = 1'b0;
               end else begin
                  m_ts++;
                  plan.push_back(mk(K_TS, 0, 0));
               end
            end
         end else if (start) begin
            m_run = 1'b1;
            m_ts  = 0;
            plan.push_back(mk(K_TS, 0, 0));
         end
      end
   end

   // Every-cycle comparison of the main DUT against the model
   always @(negedge clk) begin
      ent_t e;
      bit   act;
      if (chk_en) begin
         act = m_run;
         e = act ? plan[0] : mk(-1, 0, 0);
         chk("busy",  int'(busy), int'(act));
         chk("we",    int'(c_neuron_we), int'(act && e.kind != K_TS));
         chk("mode",  int'(c_mode), int'(act && e.kind == K_UPD));
         chk("nidx",  int'(c_neuron_index), act ? e.n : 0);
         chk("syn",   int'(c_synapse_index), (act && e.kind == K_ACC) ? e.syn : 0);
         chk("done",  int'(done), int'(act && e.kind == K_UPD && e.n == NR - 1 && m_ts == MAXT - 1));
         chk("ready", int'(ext_ready), int'(!reset && q.size() < QD && !(act && e.kind == K_UPD && fire)));
         chk("ts",    int'(timestep), m_ts);
         chk("drops", int'(drop_count), m_drops);
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; ext_valid = 1'b0; fire = 1'b0;
      cyc(1);
      reset = 1'b0;
      #1;
   endtask

   task automatic wait_pt(input bit mode, input int ts, input int n);
      int k = 0;
      while (!(busy && c_neuron_we && c_mode == mode &&
               int'(timestep) == ts && int'(c_neuron_index) == n)) begin
         if (k >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_pt mode=%0d ts=%0d n=%0d: not reached within %0d cycles", mode, ts, n, k);
            return;
         end
         cyc(1);
         k++;
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},  int'(busy), 0);
      chk({tag, "_we"},    int'(c_neuron_we), 0);
      chk({tag, "_mode"},  int'(c_mode), 0);
      chk({tag, "_nidx"},  int'(c_neuron_index), 0);
      chk({tag, "_syn"},   int'(c_synapse_index), 0);
      chk({tag, "_ts"},    int'(timestep), 0);
      chk({tag, "_drops"}, int'(drop_count), 0);
      chk({tag, "_ready"}, int'(ext_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_seen;
      // ---------------- reset state ----------------
      cyc(2);
      reset = 1'b0;
      #1;
      chk_idle("rst");

      // ---------------- empty timestep ----------------
      start = 1'b1; cyc(1); start = 1'b0;
      chk("s1_ts_start_we", int'(c_neuron_we), 0);
      chk("s1_busy", int'(busy), 1);
      cyc(1);
      chk("s1_upd_mode", int'(c_mode), 1);
      cyc(15);
      chk("s1_upd_last_nidx", int'(c_neuron_index), 15);
      chk("s1_ts_still0", int'(timestep), 0);
      cyc(1);
      chk("s1_ts1", int'(timestep), 1);
      do_reset();

      // ---------------- two external events ----------------
      ext_index = 14'd100; ext_valid = 1'b1; cyc(1);
      ext_index = 14'd200; cyc(1);
      ext_valid = 1'b0;
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(1);
      chk("s2_acc_row100", int'(c_synapse_index), 100);
      cyc(16);
      chk("s2_acc_row200", int'(c_synapse_index), 200);
      cyc(16);
      chk("s2_upd_mode", int'(c_mode), 1);
      cyc(16);
      chk("s2_ts1_at49", int'(timestep), 1);
      cyc(17);
      chk("s2_ts2_empty_queue", int'(timestep), 2);

      // ---------------- recurrent fires ----------------
      wait_pt(1'b1, 2, 3); fire = 1'b1; cyc(1); fire = 1'b0;
      wait_pt(1'b1, 2, 7); fire = 1'b1; cyc(1); fire = 1'b0;
      wait_pt(1'b0, 3, 0);
      chk("s3_acc_row3", int'(c_synapse_index), 3);
      ext_index = 14'd500; ext_valid = 1'b1;
      #1;
      chk("s3_ext_ready_acc", int'(ext_ready), 1);
      cyc(1); ext_valid = 1'b0;
      cyc(15);
      chk("s3_acc_row7", int'(c_synapse_index), 7);
      wait_pt(1'b0, 4, 0);
      chk("s3_ext_next_ts", int'(c_synapse_index), 500);
      do_reset();

      // ---------------- full queue, drops, arbitration ----------------
      for (int i = 0; i < 8; i++) begin
         ext_index = 14'(1000 + i); ext_valid = 1'b1; cyc(1);
      end
      ext_index = 14'd1008;
      #1;
      chk("s4_full_not_ready", int'(ext_ready), 0);
      cyc(1);
      ext_index = 14'd2000; start = 1'b1; cyc(1); start = 1'b0;
      for (int i = 0; i < 131; i++) begin
         ext_index = ext_index + 14'd1; cyc(1);
      end
      ext_valid = 1'b0;
      #1;
      chk("s4_upd_full_ready", int'(ext_ready), 0);
      cyc(3);
      fire = 1'b1; cyc(1); fire = 1'b0;
      chk("s4_drop_one", int'(drop_count), 1);
      wait_pt(1'b1, 1, 2);
      fire = 1'b1; ext_valid = 1'b1; ext_index = 14'd3000;
      #1;
      chk("s4_fire_blocks_ext", int'(ext_ready), 0);
      cyc(1); fire = 1'b0;
      #1;
      chk("s4_ext_next_cycle", int'(ext_ready), 1);
      cyc(1); ext_valid = 1'b0;
      wait_pt(1'b0, 2, 0);
      chk("s4_fire_row2", int'(c_synapse_index), 2);
      cyc(16);
      chk("s4_ext_row3000", int'(c_synapse_index), 3000);
      do_reset();
      chk_idle("s4_rst");

      // ---------------- reset mid-accumulate ----------------
      for (int i = 5; i < 8; i++) begin
         ext_index = 14'(i); ext_valid = 1'b1; cyc(1);
      end
      ext_valid = 1'b0;
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(20);
      chk("s6_mid_acc_row6", int'(c_synapse_index), 6);
      reset = 1'b1; cyc(1); reset = 1'b0;
      #1;
      chk_idle("s6_rst");
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(16);
      chk("s6_upd_last", int'(c_neuron_index), 15);
      cyc(1);
      chk("s6_ts1_at17", int'(timestep), 1);

      // ---------------- short run with done ----------------
      done_seen = 0;
      start4 = 1'b1; cyc(1); start4 = 1'b0;
      for (int i = 0; i < 68; i++) begin
         chk("s5_done_pos", int'(done4), (i == 67) ? 1 : 0);
         if (done4) done_seen++;
         if (i < 67) cyc(1);
      end
      start4 = 1'b1;
      #1;
      chk("s5_done_ts3", int'(timestep4), 3);
      cyc(1);
      start4 = 1'b0;
      chk("s5_done_count", done_seen, 1);
      chk("s5_idle_after", int'(busy4), 0);
      chk("s5_ts_hold", int'(timestep4), 3);
      start4 = 1'b1; cyc(1); start4 = 1'b0;
      chk("s5_restart_busy", int'(busy4), 1);
      chk("s5_restart_ts0", int'(timestep4), 0);

      cyc(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spike_event_scheduler.md
Name: spike_event_scheduler

Overview:
Timestep scheduler for the time-multiplexed neuron datapath (neuron SRAM, synapse SRAM, accumulator, neuron processor). Buffers spike events in one event FIFO and arbitrates its single write port between external input spikes and recurrent fire events from the neuron processor. Each timestep runs in two phases. The accumulate phase drains a snapshot of the queue, sweeping all neurons once per event. The update phase sweeps all neurons once and collects fire events for the next timestep.

Parameters:
NR_DEPTH, 16, number of neurons (neuron SRAM depth)
SR_DEPTH, 16384, synapse SRAM rows; an event is a synapse row index
EVQ_DEPTH, 8, event FIFO entries (power of two)
MAX_NETWORK_TIME, 65536, timesteps per run

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin a run; ignored unless IDLE
ext_valid  in  1  external spike event valid
ext_index  in  $clog2(SR_DEPTH)  external event synapse row
ext_ready  out  1  external event accepted when valid&ready
fire  in  1  neuron processor fired for current c_neuron_index
c_neuron_index  out  $clog2(NR_DEPTH)  neuron SRAM address
c_synapse_index  out  $clog2(SR_DEPTH)  synapse SRAM row of event being applied
c_neuron_we  out  1  neuron SRAM write enable
c_mode  out  1  0=accumulate, 1=update
timestep  out  $clog2(MAX_NETWORK_TIME)  current timestep index
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of run
drop_count  out  8  saturating count of dropped fire events

Behaviour:
- Reset: state=IDLE, FIFO empty, all outputs 0 except ext_ready=1. Applies from any state, including mid-phase.
- FIFO: EVQ_DEPTH entries of $clog2(SR_DEPTH) bits. Pointers wrap modulo EVQ_DEPTH. Separate count register, 0..EVQ_DEPTH.
- Push arbitration (fixed priority, fire > ext):
  - A fire push happens only when state=UPDATE and fire=1. It pushes row = zero-extended c_neuron_index; recurrent rows are 0..NR_DEPTH-1.
  - ext_ready = !full && !(state==UPDATE && fire). This is combinational and does not depend on a same-cycle pop.
  - ext_ready also requires reset=0; pushes are accepted in every other state.
- Full on a fire push: the event is dropped and drop_count increments, saturating at 255. drop_count clears only on reset.
- Push and pop in the same cycle leave count unchanged.
- FSM states: IDLE, TS_START, ACC, UPDATE.
- IDLE:
  - c_neuron_we=0.
  - On start: timestep<=0, go to TS_START.
- TS_START (1 cycle):
  - Latch pending<=count.
  - c_neuron_we=0.
  - Go to ACC if pending>0, else UPDATE.
  - Events pushed after this cycle belong to the next timestep.
- ACC:
  - Outputs: c_mode=0, c_neuron_we=1, c_synapse_index=FIFO head, combinational read.
  - c_neuron_index steps 0..NR_DEPTH-1, one neuron per cycle.
  - On neuron NR_DEPTH-1: pop the head and decrement pending. Then go to UPDATE if pending becomes 0; otherwise restart at neuron 0.
- UPDATE:
  - Outputs: c_mode=1, c_neuron_we=1, c_synapse_index=0.
  - c_neuron_index steps 0..NR_DEPTH-1. fire is sampled in the same cycle as its neuron index.
  - No pops occur.
  - On neuron NR_DEPTH-1:
    - If timestep==MAX_NETWORK_TIME-1: pulse done, go to IDLE, timestep holds its value.
    - Otherwise: timestep<=timestep+1, go to TS_START.
- Timestep latency with P snapshotted events = 1 + P*NR_DEPTH + NR_DEPTH cycles.
- c_neuron_index=0 whenever state is IDLE or TS_START.
- start while busy: ignored. done and start in the same cycle: start is ignored, because done is asserted in UPDATE.
- FIFO contents persist across runs; only reset clears them.

Test Plan:
- Reset, then start with empty FIFO: TS_START 1 cycle, then 16 UPDATE cycles (c_mode=1, index 0..15, we=1); timestep 0->1 after cycle 17; busy=1 throughout.
- Push ext rows 100 then 200 in IDLE, then start: 16 ACC cycles with c_synapse_index=100, then 16 with 200, then 16 UPDATE; 49 cycles per timestep; FIFO count 0 afterwards.
- Assert fire at neurons 3 and 7 in timestep 0 UPDATE: timestep 1 ACC applies row 3 then row 7 (32 cycles); ext_valid held during ACC is accepted but applied only in timestep 2.
- Fill FIFO with 8 ext events: ext_ready=0 at full. Fire during UPDATE while full: drop_count=1, FIFO unchanged. Fire and ext_valid in the same UPDATE cycle (not full): fire pushed, ext_ready=0, ext accepted the next cycle.
- MAX_NETWORK_TIME=4 override, empty queue, start: done pulses on the last UPDATE cycle of timestep 3 (cycle 68). Then IDLE, timestep=3; the next start restarts timestep at 0.
- Reset asserted mid-ACC with 3 events pending: next cycle IDLE, count=0, all outputs 0, ext_ready=1; start afterwards runs a 17-cycle empty timestep.
